crc_req_scheduler: RTL and testbench

//  Shares one crc14 encoder core (8-bit message -> 22-bit codeword {msg, crc14}) among NUM_REQ requesters.

---
 rtl/crc_pkg.sv | 9 +
 rtl/crc_rr_pick.sv | 30 +++
 rtl/crc_req_scheduler.sv | 101 ++++++++++
 tb/tb_crc_req_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared widths, polynomial and scheduler state encoding for the crc14 request path.
package crc_pkg;
  localparam int MSG_W = 8;
  localparam int CRC_W = 14;
  localparam int CW_W  = MSG_W + CRC_W;
  localparam logic [CRC_W-1:0] CRC_POLY = 14'h0599;

  typedef enum logic [1:0] {SCH_IDLE, SCH_ISSUE, SCH_WAIT, SCH_RESP} sch_state_t;
endpackage

// File: rtl/crc_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping.
module crc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    grant
);
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Walk offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (req_valid[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end
endmodule

// File: rtl/crc_req_scheduler.sv
// Round-robin scheduler sharing one crc14 encoder core among NUM_REQ requesters,
// one job in flight, with a per-job watchdog that aborts a stuck encode.
module crc_req_scheduler
  import crc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*MSG_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [CW_W-1:0]            rsp_codeword,
  output logic                       rsp_err,
  output logic                       enc_start,
  output logic [MSG_W-1:0]           enc_data,
  input  logic                       enc_done,
  input  logic [CW_W-1:0]            enc_codeword,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT-1);

  sch_state_t      state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            any;
  logic [WD_W-1:0] wdog;
  logic            timeout;

  crc_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (any),
    .grant     (grant)
  );

  assign timeout   = (wdog == WD_LAST);
  assign enc_start = (state == SCH_ISSUE);
  assign rsp_valid = (state == SCH_RESP);
  assign busy      = (state != SCH_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCH_IDLE;
    else     state <= state_nxt;
  end

  // Accept pulse is masked by rst so outputs sit at reset values while it is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      SCH_IDLE: if (any) begin
        state_nxt = SCH_ISSUE;
        req_ready[grant] = !rst;
      end
      SCH_ISSUE: state_nxt = SCH_WAIT;
      SCH_WAIT:  if (enc_done || timeout) state_nxt = SCH_RESP;
      SCH_RESP:  if (rsp_ready) state_nxt = SCH_IDLE;
      default:   state_nxt = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      rsp_id       <= '0;
      rsp_codeword <= '0;
      rsp_err      <= 1'b0;
      enc_data     <= '0;
      wdog         <= '0;
    end else begin
      case (state)
        SCH_IDLE: if (any) begin
          enc_data <= req_data[grant*MSG_W +: MSG_W];
          rsp_id   <= grant;
        end
        SCH_ISSUE: wdog <= '0;
        SCH_WAIT: begin
          wdog <= wdog + 1'b1;
          // A completion in the same cycle as the watchdog expiry still counts.
          if (enc_done) begin
            rsp_codeword <= enc_codeword;
            rsp_err      <= 1'b0;
          end else if (timeout) begin
            rsp_codeword <= '0;
            rsp_err      <= 1'b1;
          end
        end
        SCH_RESP: if (rsp_ready)
          rr_ptr <= (rsp_id == ID_W'(NUM_REQ-1)) ? '0 : rsp_id + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_req_scheduler.sv
// Bench for crc_req_scheduler: behavioural encoder core (normal, silent, late) plus directed and random jobs.
module tb_crc_req_scheduler;
  import crc_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [21:0]    rsp_codeword;
  logic           rsp_err;
  logic           enc_start;
  logic [7:0]     enc_data;
  logic           enc_done;
  logic [21:0]    enc_codeword;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  int core_lat = 3;
  logic [7:0] core_msg;

  crc_req_scheduler #(.NUM_REQ(N), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_codeword(rsp_codeword),
    .rsp_err(rsp_err), .enc_start(enc_start), .enc_data(enc_data), .enc_done(enc_done),
    .enc_codeword(enc_codeword), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Remainder of msg * x^14 divided by the generator polynomial.
  function automatic logic [CRC_W-1:0] ref_crc(input logic [7:0] m);
    logic [CW_W-1:0] r;
    r = {m, {CRC_W{1'b0}}};
    for (int b = CW_W-1; b >= CRC_W; b--)
      if (r[b]) r = r ^ (CW_W'({1'b1, CRC_POLY}) << (b - CRC_W));
    return r[CRC_W-1:0];
  endfunction

  // Encoder core model: done 3 cycles after start; core_lat=0 never answers.
  always begin
    @(negedge clk);
    if (enc_start && !rst && core_lat > 0) begin
      core_msg = enc_data;
      repeat (core_lat) @(posedge clk);
      #1 enc_done = 1'b1; enc_codeword = {core_msg, ref_crc(core_msg)};
      @(posedge clk);
      #1 enc_done = 1'b0; enc_codeword = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id), 0);
    chk({tag, "_rsp_cw"},    32'(rsp_codeword), 0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 0);
    chk({tag, "_enc_start"}, 32'(enc_start), 0);
    chk({tag, "_enc_data"},  32'(enc_data), 0);
    chk({tag, "_busy"},      32'(busy), 0);
  endtask

  // One job end to end against the model; returns observed rsp_id and grant cycle.
  task automatic do_job(input int hold, input int exp_lat, input bit exp_err,
                        output int id_obs, output int tg);
    int g, k, t0;
    logic [7:0]  d;
    logic [21:0] cw;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (g < 0 && req_valid[j]) g = j;
    end
    if (g < 0) g = 0;
    k = 0;
    while (req_ready == '0 && k < 20) begin tick(); k++; end
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("busy_idle", 32'(busy), 0);
    d  = req_data[8*g +: 8];
    cw = exp_err ? 22'h0 : {d, ref_crc(d)};
    t0 = cyc; tg = cyc;
    tick();
    chk("enc_start", 32'(enc_start), 1);
    chk("enc_data", 32'(enc_data), 32'(d));
    chk("no_ready_busy", 32'(req_ready), 0);
    k = 0;
    while (!rsp_valid && k < 40) begin tick(); k++; end
    chk("rsp_latency", 32'(cyc - t0), 32'(exp_lat));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_cw", 32'(rsp_codeword), 32'(cw));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    id_obs = int'(rsp_id);
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_cw", 32'(rsp_codeword), 32'(cw));
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_ready", 32'(req_ready), 0);
      chk("hold_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 0);
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int id, tg, prev;
    int seq3[4];
    seq3 = '{1, 3, 1, 3};
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    enc_done = 1'b0; enc_codeword = '0;
    #3 chk_reset("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // All four valid with zero data: grants in order, 6 cycles apart.
    req_valid = 4'hF; req_data = '0; prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_job(0, 5, 1'b0, id, tg);
      req_valid[i] = 1'b0;
      chk("t2_order", 32'(id), 32'(i));
      if (i > 0) chk("t2_gap", 32'(tg - prev), 6);
      prev = tg;
    end

    // Single requester 0, msg 0x01, consumer stalls 10 cycles in RESP.
    req_valid = 4'b0001; req_data = 32'h0000_0001;
    do_job(10, 5, 1'b0, id, tg);
    req_valid = '0;

    // Requesters 1 and 3 held valid: strict alternation.
    req_valid = 4'b1010; req_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      do_job(0, 5, 1'b0, id, tg);
      chk("t3_seq", 32'(id), 32'(seq3[i]));
    end
    req_valid = '0;

    // Silent core: watchdog aborts after 16 WAIT cycles.
    core_lat = 0;
    req_valid = 4'b0100; req_data = $urandom;
    do_job(0, 18, 1'b1, id, tg);
    req_valid = '0;

    // Late core: done arrives while the aborted response is still held.
    core_lat = 20;
    req_valid = 4'b0001; req_data = $urandom;
    do_job(10, 18, 1'b1, id, tg);
    req_valid = '0;
    repeat (4) tick();
    core_lat = 3;

    // Reset during WAIT, then the pointer restarts from 0.
    req_valid = 4'b1001; req_data = $urandom;
    #1;
    chk("t6_pre_grant", 32'(req_ready), 32'h8);
    tick(); tick();
    chk("t6_in_wait", 32'(busy), 1);
    #1 rst = 1'b1;
    #1 chk_reset("t6_async");
    repeat (3) begin tick(); chk_reset("t6_held"); end
    rst = 1'b0;
    m_ptr = 0;
    do_job(0, 5, 1'b0, id, tg);
    chk("t6_restart", 32'(id), 0);
    req_valid = '0;

    // Random masks, data and consumer stalls.
    for (int n = 0; n < 30; n++) begin
      req_valid = N'($urandom_range(1, 15));
      req_data  = $urandom;
      do_job($urandom_range(0, 3), 5, 1'b0, id, tg);
    end
    req_valid = '0;
    tick();
    chk("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
